// File: rtl/arm_cond_pkg.sv
// Shared encodings for ARM-style conditional execution: Cond field values,
// NZCV bit positions and decoder flag-write request bits.
package arm_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational Cond-field evaluator against an NZCV snapshot.
// Odd encodings are the complement of the preceding even one, except 1111.
module cond_check
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_ex,
    output logic       illegal
);

    logic n_s, z_s, c_s, v_s;
    logic base_s;

    assign n_s = nzcv[FLAG_N];
    assign z_s = nzcv[FLAG_Z];
    assign c_s = nzcv[FLAG_C];
    assign v_s = nzcv[FLAG_V];

    // Evaluate the even member of each condition pair.
    always_comb begin
        base_s = 1'b0;
        case (cond[3:1])
            3'd0:    base_s = z_s;
            3'd1:    base_s = c_s;
            3'd2:    base_s = n_s;
            3'd3:    base_s = v_s;
            3'd4:    base_s = c_s & ~z_s;
            3'd5:    base_s = (n_s == v_s);
            3'd6:    base_s = ~z_s & (n_s == v_s);
            3'd7:    base_s = 1'b1;
            default: base_s = 1'b0;
        endcase
    end

    // Apply pair inversion and trap the reserved encoding.
    always_comb begin
        cond_ex = 1'b0;
        illegal = 1'b0;
        if (cond == COND_NV) begin
            cond_ex = 1'b0;
            illegal = 1'b1;
        end else begin
            cond_ex = base_s ^ cond[0];
            illegal = 1'b0;
        end
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: owns NZCV, gates decoder write requests with the
// condition result, and counts squashed instructions (saturating).
module cond_unit
    import arm_cond_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             stall,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic [1:0]       reg_w_req,
    input  logic             mem_w_req,
    input  logic             pcs_req,
    input  logic             clr_cnt,
    output logic [1:0]       reg_write,
    output logic             mem_write,
    output logic             pc_src,
    output logic             cond_ex,
    output logic             illegal_cond,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0]       flags_r;
    logic [CNT_W-1:0] squash_cnt_r;
    logic             cond_ex_s;
    logic             nv_s;
    logic             go_s;
    logic             fail_s;

    cond_check u_cond_check (
        .cond    (cond),
        .nzcv    (flags_r),
        .cond_ex (cond_ex_s),
        .illegal (nv_s)
    );

    assign go_s         = valid & ~stall & cond_ex_s;
    assign fail_s       = valid & ~stall & ~cond_ex_s;
    assign cond_ex      = cond_ex_s;
    assign illegal_cond = valid & nv_s;
    assign flags        = flags_r;
    assign squash_cnt   = squash_cnt_r;

    // Committed write enables; zero latency so the datapath acts this cycle.
    always_comb begin
        reg_write = 2'b00;
        mem_write = 1'b0;
        pc_src    = 1'b0;
        if (!reset && go_s) begin
            reg_write = reg_w_req;
            mem_write = mem_w_req;
            pc_src    = pcs_req;
        end else begin
            reg_write = 2'b00;
            mem_write = 1'b0;
            pc_src    = 1'b0;
        end
    end

    // NZCV register: N,Z and C,V halves written independently on a passing instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= FLAG_RST;
        end else if (go_s) begin
            if (flag_w[FW_NZ]) begin
                flags_r[FLAG_N] <= alu_flags[FLAG_N];
                flags_r[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (flag_w[FW_CV]) begin
                flags_r[FLAG_C] <= alu_flags[FLAG_C];
                flags_r[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

    // Saturating squash counter; clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            squash_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            squash_cnt_r <= {CNT_W{1'b0}};
        end else if (fail_s && (squash_cnt_r != {CNT_W{1'b1}})) begin
            squash_cnt_r <= squash_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes expected outputs computed by a
// behavioural model; a monitor pops and compares each cycle at the falling edge.
module tb_cond_unit;

    logic        clk;
    logic        reset;
    logic        valid;
    logic        stall;
    logic [3:0]  cond;
    logic [3:0]  alu_flags;
    logic [1:0]  flag_w;
    logic [1:0]  reg_w_req;
    logic        mem_w_req;
    logic        pcs_req;
    logic        clr_cnt;
    logic [1:0]  reg_write;
    logic        mem_write;
    logic        pc_src;
    logic        cond_ex;
    logic        illegal_cond;
    logic [3:0]  flags;
    logic [15:0] squash_cnt;

    cond_unit #(.CNT_W(16), .FLAG_RST(4'b0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .stall        (stall),
        .cond         (cond),
        .alu_flags    (alu_flags),
        .flag_w       (flag_w),
        .reg_w_req    (reg_w_req),
        .mem_w_req    (mem_w_req),
        .pcs_req      (pcs_req),
        .clr_cnt      (clr_cnt),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .pc_src       (pc_src),
        .cond_ex      (cond_ex),
        .illegal_cond (illegal_cond),
        .flags        (flags),
        .squash_cnt   (squash_cnt)
    );

    typedef struct packed {
        logic [1:0]  rw;
        logic        mw;
        logic        ps;
        logic        cx;
        logic        il;
        logic [3:0]  fl;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Model state: architectural flags and counter as integers.
    logic [3:0] m_flags;
    int         m_cnt;
    bit         m_known = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM condition table stated directly in terms of N,Z,C,V.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !cc || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input logic rst, input logic vld, input logic stl,
                        input logic [3:0] cnd, input logic [3:0] af,
                        input logic [1:0] fw, input logic [1:0] rw,
                        input logic mw, input logic ps, input logic clr);
        exp_t e;
        bit   pass, go;
        @(posedge clk);
        #1;
        reset = rst; valid = vld; stall = stl; cond = cnd; alu_flags = af;
        flag_w = fw; reg_w_req = rw; mem_w_req = mw; pcs_req = ps; clr_cnt = clr;
        if (m_known) begin
            pass  = cond_pass(cnd, m_flags);
            go    = vld && !stl && pass && !rst;
            e.rw  = go ? rw : 2'b00;
            e.mw  = go && mw;
            e.ps  = go && ps;
            e.cx  = pass;
            e.il  = vld && (cnd == 4'hF);
            e.fl  = m_flags;
            e.cnt = m_cnt[15:0];
            exp_q.push_back(e);
        end
        if (rst) begin
            m_flags = 4'b0000;
            m_cnt   = 0;
            m_known = 1;
        end else if (m_known) begin
            if (go && fw[1]) m_flags[3:2] = af[3:2];
            if (go && fw[0]) m_flags[1:0] = af[1:0];
            if (clr) m_cnt = 0;
            else if (vld && !stl && !pass && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expected entry.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {reg_write, mem_write, pc_src, cond_ex, illegal_cond, flags, squash_cnt};
                checks++;
                if (a === e) passes++;
                else $display("FAIL outputs t=%0t got rw=%b mw=%b ps=%b cx=%b il=%b fl=%b cnt=%h want rw=%b mw=%b ps=%b cx=%b il=%b fl=%b cnt=%h",
                              $time, a.rw, a.mw, a.ps, a.cx, a.il, a.fl, a.cnt,
                              e.rw, e.mw, e.ps, e.cx, e.il, e.fl, e.cnt);
            end
        end
    end

    initial begin
        reset = 1'b1; valid = 1'b0; stall = 1'b0; cond = 4'h0; alu_flags = 4'h0;
        flag_w = 2'b00; reg_w_req = 2'b00; mem_w_req = 1'b0; pcs_req = 1'b0; clr_cnt = 1'b0;
        //    rst  vld  stl  cond   af       fw     rw     mw   ps   clr
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0);
        // EQ fails on zero flags, NE passes
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
        // CMP then BEQ back-to-back, then BNE
        step(1'b0, 1'b1, 1'b0, 4'hE, 4'b0100, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        // Reset, then failed CMPEQ must not touch flags
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        // NZ-only write, then GE / LT
        step(1'b0, 1'b1, 1'b0, 4'hE, 4'b1011, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'hA, 4'h0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'hB, 4'h0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        // Stalled passing STR, then reserved cond
        step(1'b0, 1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        // Drive the counter to saturation (flags N=1,Z=0 so EQ fails)
        while (m_cnt < 65535)
            step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        // Reset overrides a passing flag-setting instruction
        step(1'b0, 1'b1, 1'b0, 4'hE, 4'b0110, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom),
                 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 15) == 0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage directly downstream of the instruction decoder (controlUnit).
- Holds the architectural NZCV flags register and evaluates the 4-bit Cond field against it.
- Gates the decoder's raw RegWrite, MemWrite and PCSrc requests into committed write enables for the datapath.
- Keeps a saturating count of squashed (condition-failed) instructions for debug.

Parameters:
- CNT_W, 16, width of squashed-instruction counter
- FLAG_RST, 4'b0000, reset value of NZCV register (bit3=N, bit2=Z, bit1=C, bit0=V)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- valid  in  1  decoded instruction present this cycle
- stall  in  1  hold: no flag update, no counter update, all write enables forced 0
- cond  in  4  instruction Cond field [31:28]
- alu_flags  in  4  NZCV produced by the ALU for the current instruction
- flag_w  in  2  decoder flag-write request; [1] writes N,Z; [0] writes C,V
- reg_w_req  in  2  decoder RegWrite request (same encoding as the decoder's RegWrite)
- mem_w_req  in  1  decoder MemWrite request
- pcs_req  in  1  decoder PCSrc request
- clr_cnt  in  1  synchronous clear of squash counter
- reg_write  out  2  committed register write enable
- mem_write  out  1  committed memory write
- pc_src  out  1  committed branch select
- cond_ex  out  1  condition passed for current instruction
- illegal_cond  out  1  cond==4'b1111 with valid=1
- flags  out  4  current NZCV register contents
- squash_cnt  out  CNT_W  number of condition-failed instructions

Behaviour:
- Reset (clk edge with reset=1): flags<=FLAG_RST, squash_cnt<=0. Reset mid-operation discards any pending flag update that cycle.
- cond_ex is combinational from cond and the registered flags, i.e. the flags before this instruction's own update:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C&!Z
  - LS 1001: !C|Z
  - GE 1010: N==V
  - LT 1011: N!=V
  - GT 1100: !Z&(N==V)
  - LE 1101: Z|(N!=V)
  - AL 1110: 1
  - 1111: 0, and illegal_cond=valid
- Define go = valid & !stall & cond_ex.
- Outputs (combinational, zero latency):
  - reg_write = go ? reg_w_req : 2'b00
  - mem_write = go & mem_w_req
  - pc_src = go & pcs_req
  - All three are 0 while reset=1.
- Flag update on clk edge when go=1:
  - if flag_w[1], N,Z <= alu_flags[3:2]
  - if flag_w[0], C,V <= alu_flags[1:0]
  - otherwise flags are held.
- A failed condition never updates flags; a failed CMP leaves NZCV untouched.
- Back-to-back: a CMP in cycle t and a BEQ in cycle t+1 see the updated Z in t+1 with no bubble.
- Squash counter increments on an edge with valid & !stall & !cond_ex (includes cond 1111). It saturates at all-ones with no wrap.
- If clr_cnt and an increment coincide, clr_cnt wins and the result is 0.
- valid=0: all enables 0, no state change, illegal_cond=0; cond_ex still reflects cond.
- stall=1: enables 0, state held, cond_ex still reflects cond.

Decomposition:
- Package arm_cond_pkg holds:
  - localparams COND_EQ..COND_AL and COND_NV (4'b1111)
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - flag_w bit indices FW_NZ=1, FW_CV=0
- Sub-module cond_check: purely combinational (cond, nzcv) -> (cond_ex, illegal). It is instantiated once and reusable by a later pipelined core.
- cond_unit owns the flags register, the gating logic and the counter.

Test Plan:
- Reset, then valid=1, cond=EQ, reg_w_req=11 -> flags=0000, cond_ex=0, reg_write=00, squash_cnt=1 after edge; cond=NE same stimulus -> reg_write=11.
- CMP (cond=AL, flag_w=11, alu_flags=0100), next cycle BEQ (cond=0000, pcs_req=1) -> flags=0100, pc_src=1; following BNE -> pc_src=0, squash_cnt+1.
- Failed CMPEQ with flags=0000, flag_w=11, alu_flags=1111 -> flags remain 0000.
- flag_w=10 with alu_flags=1011 from flags=0000 -> flags=1000 (C,V unchanged); then GE with N=1, V=0 -> cond_ex=0; LT -> cond_ex=1.
- stall=1 with a passing STR (mem_w_req=1) -> mem_write=0, flags and squash_cnt unchanged; cond=1111, valid=1 -> illegal_cond=1, all enables 0, count+1.
- Preload squash_cnt to 16'hFFFF, then a failed instruction -> stays FFFF; failed instruction with clr_cnt=1 -> 0; reset asserted during a passing flag-setting instruction -> flags=FLAG_RST.
